// File: rtl/page_flip_controller_pkg.sv
// Shared types and constants for the page-flip controller.
// Default widths match the controller's default parameters.
package page_flip_pkg;

   localparam int unsigned DEFAULT_LAYER_COUNT    = 4;
   localparam int unsigned DEFAULT_INTERVAL_WIDTH = 4;

   localparam logic [DEFAULT_INTERVAL_WIDTH-1:0] FRAMES_SAT = '1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      COMMIT
   } state_t;

   typedef logic [DEFAULT_LAYER_COUNT-1:0] layer_mask_t;

endpackage

// File: rtl/page_flip_controller_if.sv
// Requester/scanout-facing signal bundle of the page-flip controller.
// The master drives timing and requests; the slave is the controller.
interface page_flip_controller_if #(
   parameter int unsigned LAYER_COUNT    = 4,
   parameter int unsigned INTERVAL_WIDTH = 4
);

   logic                      vblank;
   logic [INTERVAL_WIDTH-1:0] interval;
   logic [LAYER_COUNT-1:0]    flip_request;
   logic [LAYER_COUNT-1:0]    flip_ready;
   logic [LAYER_COUNT-1:0]    pending;
   logic [LAYER_COUNT-1:0]    front_select;
   logic [LAYER_COUNT-1:0]    flip_done;
   logic [INTERVAL_WIDTH-1:0] frames_since_flip;

   modport master (
      output vblank,
      output interval,
      output flip_request,
      input  flip_ready,
      input  pending,
      input  front_select,
      input  flip_done,
      input  frames_since_flip
   );

   modport slave (
      input  vblank,
      input  interval,
      input  flip_request,
      output flip_ready,
      output pending,
      output front_select,
      output flip_done,
      output frames_since_flip
   );

endinterface

// File: rtl/rising_edge_detect.sv
// Registered 1-bit rising-edge detector: rise_o is high for the first
// cycle in which d_i is seen high after being low.
module rising_edge_detect (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/page_flip_controller.sv
// Collects per-layer flip requests and commits all pending flips together
// on a vblank rising edge once the programmed swap interval has elapsed.
module page_flip_controller
   import page_flip_pkg::*;
#(
   parameter int unsigned           LAYER_COUNT    = 4,
   parameter int unsigned           INTERVAL_WIDTH = 4,
   parameter logic [LAYER_COUNT-1:0] RESET_SELECT  = '0
) (
   input logic                   clock,
   input logic                   reset_n,
   page_flip_controller_if.slave bus
);

   state_t                    state_q;
   logic [LAYER_COUNT-1:0]    pending_q;
   logic [LAYER_COUNT-1:0]    front_q;
   logic [LAYER_COUNT-1:0]    done_q;
   logic [LAYER_COUNT-1:0]    mask_q;
   logic [INTERVAL_WIDTH-1:0] frames_q;

   logic                      vblank_rise;
   logic [LAYER_COUNT-1:0]    ready;
   logic [LAYER_COUNT-1:0]    accept;
   logic [INTERVAL_WIDTH-1:0] frames_inc;
   logic [INTERVAL_WIDTH:0]   frames_plus1;
   logic [INTERVAL_WIDTH:0]   interval_eff;
   logic                      interval_met;

   rising_edge_detect u_vblank_edge (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .d_i    (bus.vblank),
      .rise_o (vblank_rise)
   );

   always_comb begin
      ready  = ~pending_q & {LAYER_COUNT{state_q != COMMIT}};
      accept = bus.flip_request & ready;

      frames_inc = (frames_q == '1) ? frames_q : frames_q + 1'b1;

      // One extra bit so a saturated counter still compares as "long enough".
      frames_plus1 = {1'b0, frames_q} + {{INTERVAL_WIDTH{1'b0}}, 1'b1};
      interval_eff = (bus.interval == '0) ? {{INTERVAL_WIDTH{1'b0}}, 1'b1}
                                          : {1'b0, bus.interval};
      interval_met = frames_plus1 >= interval_eff;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         front_q   <= RESET_SELECT;
         done_q    <= '0;
         mask_q    <= '0;
         frames_q  <= '1;
      end else begin
         done_q <= '0;
         unique case (state_q)
            IDLE: begin
               pending_q <= pending_q | accept;
               if (vblank_rise) frames_q <= frames_inc;
               if (|accept) state_q <= WAIT;
            end
            WAIT: begin
               pending_q <= pending_q | accept;
               if (vblank_rise) begin
                  frames_q <= frames_inc;
                  // Same-cycle requests land in pending_q but not in the mask.
                  if (interval_met) begin
                     mask_q  <= pending_q;
                     state_q <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               front_q   <= front_q ^ mask_q;
               pending_q <= pending_q & ~mask_q;
               done_q    <= mask_q;
               frames_q  <= '0;
               state_q   <= (|(pending_q & ~mask_q)) ? WAIT : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.flip_ready        = ready;
   assign bus.pending           = pending_q;
   assign bus.front_select      = front_q;
   assign bus.flip_done         = done_q;
   assign bus.frames_since_flip = frames_q;

endmodule

// File: tb/tb_page_flip_controller.sv
// Directed bench for page_flip_controller with a non-zero reset select.
module tb_page_flip_controller;

   localparam logic [3:0] RS = 4'b0101;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   int   base;
   logic [3:0] done_last = '0;

   always #5 clk = ~clk;

   page_flip_controller_if #(.LAYER_COUNT(4), .INTERVAL_WIDTH(4)) ifc ();

   page_flip_controller #(
      .LAYER_COUNT    (4),
      .INTERVAL_WIDTH (4),
      .RESET_SELECT   (RS)
   ) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (ifc)
   );

   // Counts cycles with a flip_done pulse and remembers the last mask.
   always @(negedge clk) begin
      if (ifc.flip_done != 4'b0000) begin
         done_cnt  = done_cnt + 1;
         done_last = ifc.flip_done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic vb_edge();
      ifc.vblank = 1'b1;
      tick();
      tick();
      ifc.vblank = 1'b0;
      tick();
      tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      ifc.vblank       = 1'b0;
      ifc.interval     = 4'd1;
      ifc.flip_request = 4'b0000;
      #12;
      chk("rst_front", ifc.front_select, RS);
      chk("rst_ready", ifc.flip_ready, 4'b1111);
      chk("rst_pending", ifc.pending, 4'b0000);
      chk("rst_frames", ifc.frames_since_flip, 4'hF);
      chk("rst_done", ifc.flip_done, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Idle: edges without requests never flip.
      base = done_cnt;
      repeat (3) vb_edge();
      chk("idle_done", done_cnt - base, 0);
      chk("idle_frames_sat", ifc.frames_since_flip, 4'hF);
      chk("idle_front", ifc.front_select, RS);

      // Single flip on layer 0.
      repeat (2) tick();
      ifc.flip_request = 4'b0001;
      tick();
      ifc.flip_request = 4'b0000;
      chk("single_pending", ifc.pending, 4'b0001);
      chk("single_ready", ifc.flip_ready, 4'b1110);
      repeat (5) tick();
      ifc.vblank = 1'b1;
      tick();
      chk("commit_ready", ifc.flip_ready, 4'b0000);
      chk("commit_front_hold", ifc.front_select, RS);
      tick();
      chk("single_front", ifc.front_select, 4'b0100);
      chk("single_done", ifc.flip_done, 4'b0001);
      chk("single_pending_clr", ifc.pending, 4'b0000);
      chk("single_frames", ifc.frames_since_flip, 4'h0);
      tick();
      chk("single_done_pulse", ifc.flip_done, 4'b0000);
      ifc.vblank = 1'b0;
      tick();

      // Batched: layers 1 and 3 requested apart, committed together.
      ifc.flip_request = 4'b0010;
      tick();
      ifc.flip_request = 4'b0000;
      repeat (3) tick();
      ifc.flip_request = 4'b1000;
      tick();
      ifc.flip_request = 4'b0000;
      chk("batch_pending", ifc.pending, 4'b1010);
      base = done_cnt;
      vb_edge();
      chk("batch_done_cnt", done_cnt - base, 1);
      chk("batch_done_mask", done_last, 4'b1010);
      chk("batch_front", ifc.front_select, 4'b1110);
      chk("batch_pending_clr", ifc.pending, 4'b0000);

      // Interval gating with interval=3.
      ifc.interval     = 4'd3;
      ifc.flip_request = 4'b0100;
      tick();
      ifc.flip_request = 4'b0000;
      base = done_cnt;
      vb_edge();
      chk("gate_frames1", ifc.frames_since_flip, 4'h1);
      chk("gate_done1", done_cnt - base, 0);
      vb_edge();
      chk("gate_frames2", ifc.frames_since_flip, 4'h2);
      chk("gate_done2", done_cnt - base, 0);
      chk("gate_pending", ifc.pending, 4'b0100);
      vb_edge();
      chk("gate_frames3", ifc.frames_since_flip, 4'h0);
      chk("gate_done3", done_cnt - base, 1);
      chk("gate_done_mask", done_last, 4'b0100);
      chk("gate_front", ifc.front_select, 4'b1010);

      // Request in the same cycle as the edge waits for the next edge.
      ifc.interval     = 4'd1;
      ifc.flip_request = 4'b0001;
      tick();
      ifc.flip_request = 4'b0010;
      ifc.vblank       = 1'b1;
      tick();
      ifc.flip_request = 4'b0000;
      chk("simul_pending", ifc.pending, 4'b0011);
      tick();
      chk("simul_done", ifc.flip_done, 4'b0001);
      chk("simul_front", ifc.front_select, 4'b1011);
      chk("simul_pending_left", ifc.pending, 4'b0010);
      ifc.vblank = 1'b0;
      repeat (2) tick();
      chk("simul_ready_wait", ifc.flip_ready, 4'b1101);
      base = done_cnt;
      vb_edge();
      chk("simul_next_cnt", done_cnt - base, 1);
      chk("simul_next_mask", done_last, 4'b0010);
      chk("simul_next_front", ifc.front_select, 4'b1001);
      chk("simul_next_pending", ifc.pending, 4'b0000);

      // Reset asserted during COMMIT.
      ifc.flip_request = 4'b1000;
      tick();
      ifc.flip_request = 4'b0000;
      ifc.vblank       = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_front", ifc.front_select, RS);
      chk("midrst_pending", ifc.pending, 4'b0000);
      chk("midrst_frames", ifc.frames_since_flip, 4'hF);
      chk("midrst_ready", ifc.flip_ready, 4'b1111);
      ifc.vblank = 1'b0;
      base = done_cnt;
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick();
      chk("midrst_no_done", done_cnt - base, 0);
      chk("midrst_front_after", ifc.front_select, RS);
      chk("midrst_pending_after", ifc.pending, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
